// File: rtl/demux_scan_ctrl.sv
// Scan controller feeding a 1:8 demux: steps through enabled channels in
// ascending order, dwells a programmable number of cycles on each, and gates
// the serial data so it only reaches the demux while a channel is stably selected.
module demux_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               data_in,
    output logic               d,
    output logic               s2,
    output logic               s1,
    output logic               s0,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CH_N  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned PTR_W = 4;   // 0..8, where 8 means "past the last channel"

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_nxt;
    logic [CH_N-1:0]    mask_q, mask_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic               mode_q, mode_nxt;
    logic [PTR_W-1:0]   ptr_q, ptr_nxt;
    logic [DWELL_W-1:0] cnt_q, cnt_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;

    logic [PTR_W-1:0]   hit_fwd;   // {found, index} searching from ptr_q upward
    logic [PTR_W-1:0]   hit_wrap;  // {found, index} searching from channel 0
    logic [DWELL_W-1:0] dwell_eff;

    // Lowest enabled channel with index >= p; MSB of the result flags a hit.
    function automatic logic [PTR_W-1:0] lowest_from(input logic [CH_N-1:0] m,
                                                     input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = int'(CH_N) - 1; i >= 0; i--) begin
            if (m[i] && (PTR_W'(i) >= p)) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

    assign hit_fwd   = lowest_from(mask_q, ptr_q);
    assign hit_wrap  = lowest_from(mask_q, '0);
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode; stop always wins over start.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (start && !stop && (en_mask != '0)) begin
                    state_nxt = SEEK;
                end
            end
            SEEK: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (hit_fwd[PTR_W-1] || mode_q) begin
                    state_nxt = DWELL;
                end else begin
                    state_nxt = DONE;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt_q == DWELL_W'(1)) begin
                    state_nxt = SEEK;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        mask_nxt  = mask_q;
        dwell_nxt = dwell_q;
        mode_nxt  = mode_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        sel_nxt   = sel_q;
        case (state_q)
            IDLE: begin
                if (state_nxt == SEEK) begin
                    mask_nxt  = en_mask;
                    dwell_nxt = dwell_eff;
                    mode_nxt  = mode;
                    ptr_nxt   = '0;
                end
            end
            SEEK: begin
                if (state_nxt == DWELL) begin
                    sel_nxt = hit_fwd[PTR_W-1] ? hit_fwd[SEL_W-1:0] : hit_wrap[SEL_W-1:0];
                    cnt_nxt = dwell_q;
                end
            end
            DWELL: begin
                cnt_nxt = cnt_q - DWELL_W'(1);
                if (state_nxt == SEEK) begin
                    ptr_nxt = PTR_W'(sel_q) + PTR_W'(1);
                end
            end
            default: ;
        endcase
        if ((state_nxt == IDLE) || (state_nxt == DONE)) begin
            sel_nxt = '0;
        end
        busy_nxt = (state_nxt == SEEK) || (state_nxt == DWELL);
        done_nxt = (state_nxt == DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mask_q  <= mask_nxt;
            dwell_q <= dwell_nxt;
            mode_q  <= mode_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
            sel_q   <= sel_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign {s2, s1, s0} = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    // Data only passes while a channel is stably selected.
    assign d            = data_in & (state_q == DWELL);

endmodule
